dpwm_duty_comparator: RTL and testbench

//   Downstream stage of the DPWM coarse counter: consumes the free-running Count bus and produces the PWM output.

---
 rtl/dpwm_duty_comparator.sv | 56 +++++
 tb/tb_dpwm_duty_comparator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_duty_comparator.sv
// DPWM duty comparator: compares the upstream coarse count against a shadowed duty
// and drives a registered PWM output plus a period-start strobe.
module dpwm_duty_comparator #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Count,
  input  logic         enable,
  input  logic [N:0]   duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic [N:0]   duty_active,
  output logic         pwm_out,
  output logic         period_start
);

  localparam logic [N:0] DUTY_MAX = {1'b1, {N{1'b0}}};

  logic         wrap;
  logic         xfer;
  logic         pending_full;
  logic [N:0]   pending;
  logic [N:0]   duty_clamped;

  assign wrap         = &Count;
  assign duty_ready   = rst & (~pending_full | wrap);
  assign xfer         = duty_valid & duty_ready;
  assign duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

  // The pending slot frees up on the wrap it drains into duty_active, so a
  // command offered on that same cycle is accepted without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= '0;
      pending_full <= 1'b0;
      duty_active  <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (wrap && pending_full) begin
        duty_active  <= pending;
        pending_full <= xfer;
        if (xfer) begin
          pending <= duty_clamped;
        end
      end else if (xfer) begin
        pending      <= duty_clamped;
        pending_full <= 1'b1;
      end
      pwm_out      <= enable & ({1'b0, Count} < duty_active);
      period_start <= (Count == '0);
    end
  end

endmodule

// File: tb/tb_dpwm_duty_comparator.sv
// Self-checking bench for dpwm_duty_comparator (N=2): directed scenarios plus a
// randomized run, all checked against a queue-based model of the duty pipeline.
module tb_dpwm_duty_comparator;

  logic       clk;
  logic       rst_n;
  logic [1:0] Count;
  logic       enable;
  logic [2:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic [2:0] duty_active;
  logic       pwm_out;
  logic       period_start;

  int checks;
  int failures;
  int cnt;
  int m_active;
  int m_pend[$];
  int e_pwm;
  int e_ps;

  dpwm_duty_comparator #(.N(2)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .Count        (Count),
    .enable       (enable),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_active  (duty_active),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp4(input int d);
    return (d > 4) ? 4 : d;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step(output bit acc);
    int  ready_exp;
    int  period_len;
    period_len = 4;
    Count = cnt[1:0];
    #1;
    ready_exp = (rst_n && (m_pend.size() == 0 || cnt == period_len - 1)) ? 1 : 0;
    checks++;
    if (duty_ready !== ready_exp[0]) begin
      failures++;
      $display("FAIL duty_ready cnt=%0d got=%b exp=%0d", cnt, duty_ready, ready_exp);
    end
    acc = (rst_n && duty_valid && ready_exp == 1);
    @(posedge clk);
    if (!rst_n) begin
      m_active = 0;
      m_pend.delete();
      e_pwm = 0;
      e_ps  = 0;
    end else begin
      e_pwm = (enable && cnt < m_active) ? 1 : 0;
      e_ps  = (cnt == 0) ? 1 : 0;
      if (cnt == period_len - 1 && m_pend.size() > 0) m_active = m_pend.pop_front();
      if (acc) m_pend.push_back(clamp4(int'(duty_in)));
    end
    #1;
    checks++;
    if (pwm_out !== e_pwm[0] || period_start !== e_ps[0] || duty_active !== m_active[2:0]) begin
      failures++;
      $display("FAIL outputs cnt=%0d got pwm=%b ps=%b act=%0d exp pwm=%0d ps=%0d act=%0d",
               cnt, pwm_out, period_start, duty_active, e_pwm, e_ps, m_active);
    end
    cnt = (cnt + 1) % period_len;
  endtask

  task automatic wait_cnt(input int target);
    bit a;
    for (int i = 0; i < 8 && cnt != target; i++) step(a);
    checks++;
    if (cnt != target) begin
      failures++;
      $display("FAIL wait_cnt timeout got=%0d exp=%0d", cnt, target);
    end
  endtask

  task automatic send(input int d, output int acc_cnt);
    bit a;
    acc_cnt = -1;
    duty_in = d[2:0];
    duty_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      acc_cnt = cnt;
      step(a);
      if (a) break;
    end
    duty_valid = 1'b0;
    checks++;
    if (!a) begin
      failures++;
      $display("FAIL send timeout duty=%0d", d);
    end
  endtask

  task automatic window(input string name, input logic [3:0] exp_pwm, input logic [3:0] exp_ps);
    logic [3:0] pw;
    logic [3:0] ps;
    bit a;
    wait_cnt(0);
    for (int i = 0; i < 4; i++) begin
      step(a);
      pw[3-i] = pwm_out;
      ps[3-i] = period_start;
    end
    checks++;
    if (pw !== exp_pwm || ps !== exp_ps) begin
      failures++;
      $display("FAIL window_%s got pwm=%b ps=%b exp pwm=%b ps=%b", name, pw, ps, exp_pwm, exp_ps);
    end
  endtask

  task automatic settle(input int d);
    int c;
    bit a;
    send(d, c);
    wait_cnt(0);
    for (int i = 0; i < 4; i++) step(a);
  endtask

  task automatic test_reset();
    bit a;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0 || duty_active !== 3'd0 || duty_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got pwm=%b ps=%b act=%0d rdy=%b exp all 0",
               pwm_out, period_start, duty_active, duty_ready);
    end
    step(a);
    step(a);
    rst_n = 1'b1;
    step(a);
  endtask

  task automatic test_basic();
    int c;
    bit a;
    wait_cnt(1);
    send(2, c);
    step(a);
    step(a);
    checks++;
    if (duty_active !== 3'd2) begin
      failures++;
      $display("FAIL basic_active got=%0d exp=2", duty_active);
    end
    window("basic", 4'b1100, 4'b1000);
  endtask

  task automatic test_sweep();
    int d[3] = '{0, 4, 7};
    logic [3:0] pat[3] = '{4'b0000, 4'b1111, 4'b1111};
    for (int k = 0; k < 3; k++) begin
      settle(d[k]);
      checks++;
      if (duty_active !== 3'(clamp4(d[k]))) begin
        failures++;
        $display("FAIL sweep_active duty=%0d got=%0d exp=%0d", d[k], duty_active, clamp4(d[k]));
      end
      window("sweep", pat[k], 4'b1000);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    wait_cnt(0);
    send(1, c);
    send(3, c);
    checks++;
    if (c != 3) begin
      failures++;
      $display("FAIL b2b_accept_cnt got=%0d exp=3", c);
    end
    window("b2b_first", 4'b1000, 4'b1000);
    window("b2b_second", 4'b1110, 4'b1000);
  endtask

  task automatic test_enable();
    int c;
    bit a;
    settle(3);
    wait_cnt(1);
    enable = 1'b0;
    send(1, c);
    step(a);
    step(a);
    checks++;
    if (duty_active !== 3'd1) begin
      failures++;
      $display("FAIL enable_pending_load got=%0d exp=1", duty_active);
    end
    window("disabled", 4'b0000, 4'b1000);
    enable = 1'b1;
    window("reenabled", 4'b1000, 4'b1000);
  endtask

  task automatic test_reset_mid();
    int c;
    bit a;
    settle(3);
    wait_cnt(0);
    send(2, c);
    step(a);
    rst_n = 1'b0;
    Count = cnt[1:0];
    #1;
    checks++;
    if (pwm_out !== 1'b0 || duty_active !== 3'd0 || duty_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got pwm=%b act=%0d rdy=%b exp 0 0 0", pwm_out, duty_active, duty_ready);
    end
    step(a);
    step(a);
    rst_n = 1'b1;
    wait_cnt(0);
    for (int i = 0; i < 4; i++) step(a);
    checks++;
    if (duty_active !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_no_update got=%0d exp=0", duty_active);
    end
  endtask

  task automatic test_random();
    bit a;
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      if (!duty_valid || $urandom_range(0, 3) == 0) begin
        duty_valid = ($urandom_range(0, 2) == 0);
        duty_in    = 3'($urandom_range(0, 7));
      end
      step(a);
      if (a) duty_valid = 1'b0;
      if ($urandom_range(0, 15) == 0) cnt = $urandom_range(0, 3);
    end
    duty_valid = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cnt = 0;
    m_active = 0;
    e_pwm = 0;
    e_ps = 0;
    rst_n = 1'b0;
    Count = 2'd0;
    enable = 1'b1;
    duty_in = 3'd0;
    duty_valid = 1'b0;
    test_reset();
    test_basic();
    test_sweep();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
